pc_update_unit: RTL

//  Program-counter stage directly downstream of the PC source mux in the multicycle CPU.

---
 rtl/pc_update_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/pc_update_unit.sv
// PC/EPC holder for the multicycle CPU: branch-qualified PC writes
// plus a three-state exception entry sequencer.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] EXC_BASE = 32'd253,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [31:0] exc_mem_data,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [31:0] exc_mem_addr,
  output logic        exc_mem_rd,
  output logic        exc_busy
);

  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_pc;
  logic [31:0]    r_epc;
  logic [31:0]    r_addr;
  logic           r_rd;

  logic           w_cond;
  logic           w_pc_we;
  logic [1:0]     w_code;
  logic [31:0]    w_hndl_addr;

  always_comb begin
    w_cond = 1'b0;
    unique case (branch_op)
      2'b00: w_cond = alu_zero;
      2'b01: w_cond = ~alu_zero;
      2'b10: w_cond = ~alu_gt;
      2'b11: w_cond = alu_gt;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_we = pc_write | (pc_write_cond & w_cond);

  // Reserved code 3 shares the div-by-zero handler slot.
  assign w_code      = (exc_code == 2'd3) ? 2'd2 : exc_code;
  assign w_hndl_addr = EXC_BASE + {30'd0, w_code};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pc    <= RESET_PC;
      r_epc   <= 32'd0;
      r_addr  <= 32'd0;
      r_rd    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (exc_req) begin
            r_epc   <= r_pc - 32'd4;
            r_addr  <= w_hndl_addr;
            r_rd    <= 1'b1;
            r_cnt   <= CW'(MEM_LAT);
            r_state <= S_WAIT;
          end else if (w_pc_we) begin
            r_pc <= pc_in;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_pc    <= {24'd0, exc_mem_data[7:0]};
          r_rd    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc           = r_pc;
  assign epc          = r_epc;
  assign exc_mem_addr = r_addr;
  assign exc_mem_rd   = r_rd;
  assign exc_busy     = (r_state != S_IDLE);

endmodule
